cmd_frame_tx: RTL and testbench

Command/response frame encoder for the FT245 synchronous link, FPGA→host direction. Accepts one 16-bit code plus 32-bit payload per handshake and serializes it as an 8-byte frame into the proto245s TX FIFO write port, byte order matching the host-facing sliding-window parser. A frame starts only when the FIFO has room for the whole frame, so frames are never split by backpressure. Sits in the sys_clk domain between test/control logic and the proto245s `txfifo_*` port.

---
 rtl/proto245_frame_pkg.sv | 45 ++++
 rtl/cmd_frame_tx.sv | 123 ++++++++++++
 tb/tb_cmd_frame_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/proto245_frame_pkg.sv
// Shared definitions for the proto245s command/response frame format.
// Used by the FPGA->host encoder, the command parser and host-side models.
package proto245_frame_pkg;

    // Frame delimiters: the suffix goes on the wire first and the prefix last.
    localparam logic [7:0] FRAME_PREFIX = 8'hAA;
    localparam logic [7:0] FRAME_SUFFIX = 8'h55;
    localparam int         FRAME_BYTES  = 8;

    // Well-known frame codes.
    localparam logic [15:0] CODE_TX_TEST = 16'hBEEF;
    localparam logic [15:0] CODE_RX_TEST = 16'hCAFE;
    localparam logic [15:0] CODE_LED     = 16'h1ED0;

    // One frame, packed so that wire byte i is bits [8*i +: 8]:
    // byte 0 is the suffix, bytes 1..4 the data (LSB first),
    // bytes 5..6 the code (LSB first) and byte 7 the prefix.
    typedef struct packed {
        logic [7:0]  prefix;
        logic [15:0] code;
        logic [31:0] data;
        logic [7:0]  suffix;
    } frame_t;

    // Encoder state machine.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_SEND       = 2'd2
    } tx_state_e;

    // Assemble a frame from its delimiters, code and payload.
    function automatic frame_t build_frame(input logic [7:0]  prefix,
                                           input logic [7:0]  suffix,
                                           input logic [15:0] code,
                                           input logic [31:0] data);
        frame_t f;
        f.prefix = prefix;
        f.code   = code;
        f.data   = data;
        f.suffix = suffix;
        return f;
    endfunction

endpackage

// File: rtl/cmd_frame_tx.sv
// Command/response frame encoder, FPGA->host direction.
// Takes one code+payload per valid/ready handshake and writes it as an
// 8-byte frame into the proto245s TX FIFO write port. A frame is only
// started once the FIFO has room for it, so backpressure never splits one.
//
// Handshake: a command transfers on a rising sys_clk edge where both
// cmd_valid and cmd_ready are high. cmd_valid must stay high and cmd_code /
// cmd_data stable until that edge; cmd_ready never waits on cmd_valid.
module cmd_frame_tx #(
    parameter int          DATA_W         = 8,  // only 8 is supported
    parameter int          TX_FIFO_SIZE   = 4096,
    parameter int          TX_FIFO_LOAD_W = $clog2(TX_FIFO_SIZE) + 1,
    parameter logic [7:0]  FRAME_PREFIX   = proto245_frame_pkg::FRAME_PREFIX,
    parameter logic [7:0]  FRAME_SUFFIX   = proto245_frame_pkg::FRAME_SUFFIX,
    parameter int          CNT_W          = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [15:0]               cmd_code,
    input  logic [31:0]               cmd_data,
    output logic [DATA_W-1:0]         txfifo_data,
    output logic                      txfifo_wr,
    input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
    input  logic                      txfifo_full,
    output logic                      busy,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic                      overflow_err
);

    import proto245_frame_pkg::*;

    // Room for two frames: the second frame of margin absorbs the delay
    // before our own writes show up in txfifo_load.
    localparam logic [TX_FIFO_LOAD_W-1:0] LOAD_LIMIT =
        TX_FIFO_LOAD_W'(TX_FIFO_SIZE - 2 * FRAME_BYTES);

    tx_state_e          state;
    frame_t             hold;       // latched frame, read byte by byte
    logic [2:0]         byte_idx;   // index of the byte currently on txfifo_data
    logic [2:0]         next_idx;   // index of the byte to load at the next edge
    logic [DATA_W-1:0]  tx_byte;    // byte selected for the next write
    logic               space_ok;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign space_ok  = (txfifo_load <= LOAD_LIMIT);

    // Pick the next wire byte out of the holding register.
    always_comb begin
        next_idx = (state == ST_SEND) ? byte_idx + 3'd1 : 3'd0;
        tx_byte  = '0;
        case (next_idx)
            3'd0:    tx_byte = DATA_W'(hold.suffix);
            3'd1:    tx_byte = DATA_W'(hold.data[7:0]);
            3'd2:    tx_byte = DATA_W'(hold.data[15:8]);
            3'd3:    tx_byte = DATA_W'(hold.data[23:16]);
            3'd4:    tx_byte = DATA_W'(hold.data[31:24]);
            3'd5:    tx_byte = DATA_W'(hold.code[7:0]);
            3'd6:    tx_byte = DATA_W'(hold.code[15:8]);
            3'd7:    tx_byte = DATA_W'(hold.prefix);
            default: tx_byte = '0;
        endcase
    end

    // Frame state machine: accept, wait for FIFO room, stream 8 bytes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            hold        <= '0;
            byte_idx    <= '0;
            txfifo_wr   <= 1'b0;
            txfifo_data <= '0;
            frame_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        hold  <= build_frame(FRAME_PREFIX, FRAME_SUFFIX,
                                             cmd_code, cmd_data);
                        state <= ST_WAIT_SPACE;
                    end
                end
                ST_WAIT_SPACE: begin
                    // Byte 0 is registered on the same edge that enters SEND.
                    if (space_ok) begin
                        state       <= ST_SEND;
                        byte_idx    <= 3'd0;
                        txfifo_wr   <= 1'b1;
                        txfifo_data <= tx_byte;
                    end
                end
                ST_SEND: begin
                    // No stall on txfifo_full: room was checked before byte 0.
                    if (byte_idx == 3'd7) begin
                        txfifo_wr   <= 1'b0;
                        txfifo_data <= '0;
                        frame_cnt   <= frame_cnt + CNT_W'(1);
                        state       <= ST_IDLE;
                    end else begin
                        byte_idx    <= next_idx;
                        txfifo_data <= tx_byte;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    txfifo_wr <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error: a write was issued while the FIFO reported full.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow_err <= 1'b0;
        end else if (txfifo_wr && txfifo_full) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Self-checking bench for cmd_frame_tx: a reference byte model feeds an
// expected queue on every accepted command; a monitor pops and compares
// each byte the DUT writes into the TX FIFO port.
module tb_cmd_frame_tx;

  localparam int LOAD_W = 13;

  // clock/reset block
  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [15:0]       cmd_code = '0;
  logic [31:0]       cmd_data = '0;
  logic [7:0]        txfifo_data;
  logic              txfifo_wr;
  logic [LOAD_W-1:0] txfifo_load = '0;
  logic              txfifo_full = 1'b0;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic              overflow_err;

  cmd_frame_tx dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_code     (cmd_code),
    .cmd_data     (cmd_data),
    .txfifo_data  (txfifo_data),
    .txfifo_wr    (txfifo_wr),
    .txfifo_load  (txfifo_load),
    .txfifo_full  (txfifo_full),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .overflow_err (overflow_err)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         wr_count = 0;
  int         wr_cyc[int];
  logic [15:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // reference frame model: wire order suffix, data LSB..MSB, code LSB..MSB, prefix
  task automatic push_frame(input logic [15:0] code, input logic [31:0] data);
    exp_q.push_back(8'h55);
    exp_q.push_back(data[7:0]);
    exp_q.push_back(data[15:8]);
    exp_q.push_back(data[23:16]);
    exp_q.push_back(data[31:24]);
    exp_q.push_back(code[7:0]);
    exp_q.push_back(code[15:8]);
    exp_q.push_back(8'hAA);
  endtask

  // monitor: sample on the falling edge, away from the active edge
  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst_n && txfifo_wr) begin
      wr_cyc[wr_count] = cyc;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("spurious_wr", exp_q.size(), 1);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("wire_byte", txfifo_data, e);
      end
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic send_cmd(input logic [15:0] code, input logic [31:0] data, input bit hold);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_data  = data;
    while (!cmd_ready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    push_frame(code, data);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge sys_clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_frames(input string tag);
    int n = 0;
    while (frame_cnt !== exp_cnt && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, frame_cnt, exp_cnt);
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (wr_count < target && n < 100) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    check("byte_wait", wr_count, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit saw_wr;

    // reset state
    repeat (3) @(negedge sys_clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_txfifo_wr", txfifo_wr, 0);
    check("rst_txfifo_data", txfifo_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_overflow", overflow_err, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // basic frame with exact cycle timing
    send_cmd(16'hBEEF, 32'h0000_0100, 1'b0);
    check("e0_busy", busy, 1);
    check("e0_cmd_ready", cmd_ready, 0);
    check("e0_wr", txfifo_wr, 0);
    @(negedge sys_clk);
    check("e1_wr", txfifo_wr, 1);
    repeat (7) @(negedge sys_clk);
    check("e8_wr", txfifo_wr, 1);
    @(negedge sys_clk);
    check("e9_wr", txfifo_wr, 0);
    check("e9_cmd_ready", cmd_ready, 1);
    check("e9_frame_cnt", frame_cnt, 1);
    check("e9_queue_empty", exp_q.size(), 0);

    // load boundary: TX_FIFO_SIZE-15 blocks, TX_FIFO_SIZE-16 lets the frame go
    txfifo_load = LOAD_W'(4081);
    send_cmd(16'hCAFE, 32'h1234_5678, 1'b0);
    saw_wr = 1'b0;
    repeat (20) begin
      @(negedge sys_clk);
      saw_wr |= txfifo_wr;
    end
    check("load4081_no_wr", saw_wr, 0);
    check("load4081_busy", busy, 1);
    check("load4081_cmd_ready", cmd_ready, 0);
    txfifo_load = LOAD_W'(4080);
    @(negedge sys_clk);
    check("load4080_starts", txfifo_wr, 1);
    wait_frames("load_frame_cnt");
    txfifo_load = '0;

    // back-to-back commands with cmd_valid held high
    #1 base = wr_count;
    send_cmd(16'h0001, 32'hA1A2_A3A4, 1'b1);
    send_cmd(16'h0002, 32'hB1B2_B3B4, 1'b1);
    send_cmd(16'h0003, 32'hC1C2_C3C4, 1'b0);
    wait_frames("b2b_frame_cnt");
    @(negedge sys_clk);
    #1;
    check("b2b_bytes", wr_count - base, 24);
    check("b2b_frame1_len", wr_cyc[base + 7] - wr_cyc[base], 7);
    check("b2b_gap12", wr_cyc[base + 8] - wr_cyc[base + 7], 3);
    check("b2b_gap23", wr_cyc[base + 16] - wr_cyc[base + 15], 3);
    check("b2b_span", wr_cyc[base + 23] - wr_cyc[base] + 1, 28);

    // reset in the middle of a frame
    @(negedge sys_clk);
    #1 base = wr_count;
    send_cmd(16'h1ED0, 32'hDEAD_BEEF, 1'b0);
    wait_bytes(base + 4);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_wr", txfifo_wr, 0);
    check("midrst_data", txfifo_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_overflow", overflow_err, 0);
    exp_q.delete();
    exp_cnt = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1 base = wr_count;
    repeat (5) @(negedge sys_clk);
    #1;
    check("midrst_no_more_bytes", wr_count - base, 0);
    send_cmd(16'h0BAD, 32'h0102_0304, 1'b0);
    wait_frames("after_rst_frame_cnt");

    // random traffic
    for (int i = 0; i < 4; i++) begin
      txfifo_load = LOAD_W'($urandom_range(0, 4080));
      send_cmd(16'($urandom_range(0, 65535)), $urandom, 1'b0);
      wait_frames("rand_frame_cnt");
    end
    txfifo_load = '0;

    // txfifo_full during byte 4: flag sets, frame still completes
    check("pre_overflow", overflow_err, 0);
    @(negedge sys_clk);
    #1 base = wr_count;
    send_cmd(16'h5A5A, 32'h0F0E_0D0C, 1'b0);
    wait_bytes(base + 5);
    txfifo_full = 1'b1;
    @(negedge sys_clk);
    #1 txfifo_full = 1'b0;
    check("overflow_set", overflow_err, 1);
    wait_frames("overflow_frame_cnt");
    @(negedge sys_clk);
    #1;
    check("overflow_full_frame", wr_count - base, 8);
    repeat (5) @(negedge sys_clk);
    check("overflow_sticky", overflow_err, 1);

    // frame counter wrap
    force dut.frame_cnt = 16'hFFFF;
    @(negedge sys_clk);
    release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    send_cmd(16'hFFFF, 32'hFFFF_FFFF, 1'b0);
    wait_frames("wrap_frame_cnt");
    check("wrap_overflow_sticky", overflow_err, 1);

    repeat (3) @(negedge sys_clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
